icache_dm: RTL and testbench
============================

# icache_dm

Parametrised direct-mapped instruction cache between the fetch stage and a word-wide instruction memory port. Tags, valid bits and line data are held on chip. Hits return data one cycle after the request. Misses run a refill state machine that fetches the full line one word per memory handshake, then return the requested word. The block also provides a whole-cache invalidate and saturating hit/miss counters for performance measurement.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, instruction word width; must be 32
- LINES, 16, number of lines; power of two, ≥2
- WORDS, 4, words per line; power of two, ≥2
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- iCacheReq  in  1  fetch request valid; sampled only when iCacheReady=1
- iCacheReadAddr  in  ADDR_W  byte address of fetch; bits [1:0] ignored
- iCacheReady  out  1  cache can accept a request this cycle
- iCacheValid  out  1  iCacheReadData holds the requested word this cycle
- iCacheReadData  out  DATA_W  returned instruction
- iCacheFlush  in  1  one-cycle pulse: invalidate all lines
- memReq  out  1  refill beat request
- memAddr  out  ADDR_W  word-aligned refill beat address
- memAck  in  1  memRdata valid; completes the current beat
- memRdata  in  DATA_W  refill beat data
- hitCount  out  32  saturating hit counter
- missCount  out  32  saturating miss counter

## Operation
- Address split: [1:0] byte, next log2(WORDS) bits word offset, next log2(LINES) bits index, remaining bits tag.
- States: IDLE, REFILL, RESP.
- IDLE: iCacheReady=1 unless iCacheFlush=1. On an accepted request, tag compare is combinational against valid[index] and tag[index].
  - Hit: register the word, set iCacheValid=1 next cycle, increment hitCount, stay in IDLE.
  - Miss: latch address, increment missCount, go to REFILL with beat=0.
- REFILL: iCacheReady=0. memReq=1 continuously. memAddr = {tag, index, beat, 2'b00}.
  - On each memAck, write memRdata into data[index][beat] and increment beat.
  - On the ack of beat WORDS-1: set valid[index], write tag[index], latch the requested word, go to RESP.
  - Beats are fetched in order 0..WORDS-1. The critical word is not fetched first.
  - valid[index] is cleared on entry to REFILL, so a reset or abort always leaves a partial line invalid.
- RESP: iCacheValid=1 with the requested word. iCacheReady=0. Next state is IDLE.
- Flush:
  - In IDLE, flush clears every valid bit at the edge. A request in the same cycle is not accepted, because iCacheReady=0.
  - In REFILL or RESP, flush is latched as pending. It is applied on the first IDLE cycle, including over the just-filled line, and iCacheReady=0 that cycle.
- Counters saturate at 32'hFFFF_FFFF. Flush does not clear them.
- Reset values:
  - FSM state IDLE.
  - All valid bits and the pending-flush flag 0.
  - iCacheValid=0, iCacheReadData=0, memReq=0, memAddr=0, hitCount=0, missCount=0.
  - iCacheReady=1 from the first cycle after reset deasserts.
  - Tag and data arrays are not reset.

## Timing
- Hit: request at cycle N, iCacheValid=1 at N+1. Back-to-back hits are accepted every cycle (throughput 1/cycle).
- Miss with memAck every cycle: request at N, memReq=1 from N+1 through N+WORDS, RESP at N+WORDS+1, iCacheReady=1 at N+WORDS+2.
- memAck wait cycles extend REFILL one cycle each. memReq and memAddr stay stable until acked.
- memAck outside REFILL is ignored.
- Requests while iCacheReady=0 are ignored. The fetch stage holds its request.
- Reset mid-refill: memReq=0 the cycle after rst is sampled, and the line stays invalid.
- iCacheValid is a one-cycle pulse per accepted request. iCacheReadData holds its value when iCacheValid=0.

## Test plan
- Cold miss: after reset, request 0x0000_0044 with mem returning word=addr and ack every cycle.
  - memAddr sequence is 0x40, 0x44, 0x48, 0x4C.
  - RESP returns 0x0000_0044 at N+5.
  - missCount=1.
- Hits: request 0x40, 0x44, 0x48, 0x4C back-to-back after the fill.
  - Four consecutive iCacheValid pulses with matching data, no memReq.
  - hitCount=4.
- Conflict: fill 0x44, then request 0x144 (same index 4, different tag).
  - Refill 0x140..0x14C.
  - A later request to 0x44 misses again: missCount=3.
- Flush:
  - Fill 0x44, pulse iCacheFlush, then request 0x44: miss.
  - Flush raised during a refill: refill completes, then the next request to that line misses.
- Stalled memory: memAck every third cycle.
  - memAddr stays stable until each ack.
  - iCacheValid is delayed to the cycle after the 4th ack.
- Reset mid-refill: assert rst after 2 beats of the 0x44 refill.
  - memReq=0 the next cycle.
  - A request to 0x44 after reset misses and refills all 4 beats.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
interface icache_dm_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              iCacheReq;
    logic [ADDR_W-1:0] iCacheReadAddr;
    logic              iCacheReady;
    logic              iCacheValid;
    logic [DATA_W-1:0] iCacheReadData;
    logic              iCacheFlush;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memAck;
    logic [DATA_W-1:0] memRdata;
    logic [31:0]       hitCount;
    logic [31:0]       missCount;

    modport slave (
        input  iCacheReq, iCacheReadAddr, iCacheFlush, memAck, memRdata,
        output iCacheReady, iCacheValid, iCacheReadData, memReq, memAddr,
               hitCount, missCount
    );

    modport master (
        output iCacheReq, iCacheReadAddr, iCacheFlush, memAck, memRdata,
        input  iCacheReady, iCacheValid, iCacheReadData, memReq, memAddr,
               hitCount, missCount
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: single-cycle hits, in-order line refill on a miss,
// whole-cache flush and saturating hit/miss counters.
module icache_dm #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINES  = 16,
    parameter int unsigned WORDS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    icache_dm_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [OFF_W-1:0]  miss_off_q, miss_off_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              flush_pend_q, flush_pend_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              ready;
    logic              hit;
    logic              fill_beat;
    logic              last_beat;
    logic              unused_byte_off;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign req_tag         = bus.iCacheReadAddr[ADDR_W-1 -: TAG_W];
    assign req_idx         = bus.iCacheReadAddr[2+OFF_W +: IDX_W];
    assign req_off         = bus.iCacheReadAddr[2 +: OFF_W];
    assign unused_byte_off = ^bus.iCacheReadAddr[1:0];

    // A pending flush must be applied before any new lookup, so it blocks ready too.
    assign ready     = (state_q == IDLE) && !bus.iCacheFlush && !flush_pend_q;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill_beat = (state_q == REFILL) && bus.memAck;
    assign last_beat = fill_beat && (beat_q == OFF_W'(WORDS - 1));

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        miss_off_d   = miss_off_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.iCacheFlush || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (bus.iCacheReq) begin
                    if (hit) begin
                        rvalid_d  = 1'b1;
                        rdata_d   = data_q[req_idx][req_off];
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        miss_tag_d       = req_tag;
                        miss_idx_d       = req_idx;
                        miss_off_d       = req_off;
                        beat_d           = '0;
                        valid_d[req_idx] = 1'b0;
                        miss_cnt_d       = sat_inc(miss_cnt_q);
                        state_d          = REFILL;
                    end
                end
            end
            REFILL: begin
                flush_pend_d = flush_pend_q | bus.iCacheFlush;
                if (fill_beat) begin
                    beat_d = beat_q + OFF_W'(1);
                end
                if (last_beat) begin
                    valid_d[miss_idx_q] = 1'b1;
                    rvalid_d            = 1'b1;
                    // The final beat is not in the array yet, so forward it directly.
                    rdata_d = (miss_off_q == beat_q) ? bus.memRdata
                                                     : data_q[miss_idx_q][miss_off_q];
                    state_d = RESP;
                end
            end
            RESP: begin
                flush_pend_d = flush_pend_q | bus.iCacheFlush;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            miss_off_q   <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            miss_off_q   <= miss_off_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_beat) begin
            data_q[miss_idx_q][beat_q] <= bus.memRdata;
            if (last_beat) begin
                tag_q[miss_idx_q] <= miss_tag_q;
            end
        end
    end

    assign bus.iCacheReady    = ready;
    assign bus.iCacheValid    = rvalid_q;
    assign bus.iCacheReadData = rdata_q;
    assign bus.memReq         = (state_q == REFILL);
    assign bus.memAddr        = (state_q == REFILL) ? {miss_tag_q, miss_idx_q, beat_q, 2'b00} : '0;
    assign bus.hitCount       = hit_cnt_q;
    assign bus.missCount      = miss_cnt_q;
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus a randomized run
// against a line-number based cache model and a word=address memory.
module tb_icache_dm;
    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_dm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    icache_dm #(.ADDR_W(32), .DATA_W(32), .LINES(LINES), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Memory responder: 0 = ack every cycle, 1 = every third cycle, 2 = random.
    int          ack_mode = 0;
    int          unstable = 0;
    int          rcyc = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    logic        mon_ack;
    logic [31:0] beat_log [$];

    always @(negedge clk) begin
        if (bus.memReq === 1'b1 && rst === 1'b0) begin
            if (pend && bus.memAddr !== pend_addr) unstable++;
            case (ack_mode)
                0:       mon_ack = 1'b1;
                1:       mon_ack = (rcyc % 3 == 2);
                default: mon_ack = ($urandom_range(0, 2) == 0);
            endcase
            rcyc++;
            bus.memAck   = mon_ack;
            bus.memRdata = mon_ack ? bus.memAddr : 32'hDEAD_BEEF;
            if (mon_ack) beat_log.push_back(bus.memAddr);
            pend      = !mon_ack;
            pend_addr = bus.memAddr;
        end else begin
            rcyc         = 0;
            pend         = 0;
            bus.memAck   = (ack_mode == 2) && ($urandom_range(0, 3) == 0);
            bus.memRdata = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
        end
    end

    // Reference model: which memory line each cache slot holds.
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic bit model_access(input logic [31:0] a);
        logic [31:0] ln;
        int          idx;
        ln  = a / (4 * WORDS);
        idx = int'(ln % LINES);
        if (m_valid[idx] && m_line[idx] == ln) begin
            m_hits++;
            return 1'b1;
        end
        m_misses++;
        m_valid[idx] = 1'b1;
        m_line[idx]  = ln;
        return 1'b0;
    endfunction

    function automatic void model_flush();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endfunction

    // Drives one fetch, holding it until accepted; lat counts cycles from acceptance to iCacheValid.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
        int k;
        bus.iCacheReq      = 1'b1;
        bus.iCacheReadAddr = a;
        #1;
        k = 0;
        while (bus.iCacheReady !== 1'b1 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        @(negedge clk);
        bus.iCacheReq      = 1'b0;
        bus.iCacheReadAddr = $urandom;
        #1;
        lat = 1;
        while (bus.iCacheValid !== 1'b1 && lat < 200) begin
            @(negedge clk); #1;
            lat++;
        end
        d = bus.iCacheReadData;
    endtask

    task automatic test_reset();
        bus.iCacheReq = 0; bus.iCacheReadAddr = '0; bus.iCacheFlush = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_flush(); m_hits = 0; m_misses = 0;
        #1;
        n_cmp++; if (bus.iCacheReady !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bus.iCacheReady); end
        n_cmp++; if (bus.iCacheValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.iCacheValid); end
        n_cmp++; if (bus.iCacheReadData !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", bus.iCacheReadData); end
        n_cmp++; if (bus.memReq !== 1'b0 || bus.memAddr !== 32'h0) begin n_err++; $display("FAIL reset_mem: got req=%b addr=%h expected 0/0", bus.memReq, bus.memAddr); end
        n_cmp++; if (bus.hitCount !== 32'h0 || bus.missCount !== 32'h0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus.hitCount, bus.missCount); end
    endtask

    task automatic test_cold_miss();
        logic [31:0] d; int lat;
        ack_mode = 0;
        beat_log.delete();
        void'(model_access(32'h44));
        fetch(32'h44, d, lat);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL cold_latency: got %0d expected 5", lat); end
        n_cmp++; if (d !== 32'h44) begin n_err++; $display("FAIL cold_data: got %h expected 00000044", d); end
        n_cmp++; if (beat_log.size() !== 4) begin n_err++; $display("FAIL cold_beats: got %0d expected 4", beat_log.size()); end
        for (int i = 0; i < beat_log.size() && i < 4; i++) begin
            n_cmp++; if (beat_log[i] !== 32'h40 + 32'(4 * i)) begin n_err++; $display("FAIL cold_memaddr%0d: got %h expected %h", i, beat_log[i], 32'h40 + 32'(4 * i)); end
        end
        n_cmp++; if (bus.missCount !== 32'(m_misses)) begin n_err++; $display("FAIL cold_misscount: got %0d expected %0d", bus.missCount, m_misses); end
    endtask

    task automatic test_hits();
        logic [31:0] a;
        @(negedge clk); #1;
        beat_log.delete();
        for (int i = 0; i < 4; i++) begin
            a = 32'h40 + 32'(4 * i);
            void'(model_access(a));
            bus.iCacheReq = 1'b1; bus.iCacheReadAddr = a;
            #1;
            n_cmp++; if (bus.iCacheReady !== 1'b1) begin n_err++; $display("FAIL hit_ready%0d: got %b expected 1", i, bus.iCacheReady); end
            @(negedge clk); #1;
            n_cmp++; if (bus.iCacheValid !== 1'b1 || bus.iCacheReadData !== a) begin n_err++; $display("FAIL hit_data%0d: got v=%b d=%h expected v=1 d=%h", i, bus.iCacheValid, bus.iCacheReadData, a); end
            n_cmp++; if (bus.memReq !== 1'b0) begin n_err++; $display("FAIL hit_memreq%0d: got %b expected 0", i, bus.memReq); end
        end
        bus.iCacheReq = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (bus.iCacheValid !== 1'b0) begin n_err++; $display("FAIL hit_pulse: got %b expected 0", bus.iCacheValid); end
        n_cmp++; if (bus.hitCount !== 32'(m_hits)) begin n_err++; $display("FAIL hit_count: got %0d expected %0d", bus.hitCount, m_hits); end
        n_cmp++; if (beat_log.size() !== 0) begin n_err++; $display("FAIL hit_nobeats: got %0d expected 0", beat_log.size()); end
    endtask

    task automatic test_conflict();
        logic [31:0] d; int lat; bit h;
        beat_log.delete();
        h = model_access(32'h144);
        fetch(32'h144, d, lat);
        n_cmp++; if (h || lat !== 5 || d !== 32'h144) begin n_err++; $display("FAIL conflict_fill: got lat=%0d d=%h expected lat=5 d=00000144 (model hit=%b)", lat, d, h); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (beat_log.size() <= i || beat_log[i] !== 32'h140 + 32'(4 * i)) begin n_err++; $display("FAIL conflict_memaddr%0d: got %h expected %h", i, (beat_log.size() > i) ? beat_log[i] : 32'hX, 32'h140 + 32'(4 * i)); end
        end
        h = model_access(32'h44);
        fetch(32'h44, d, lat);
        n_cmp++; if (lat !== 5 || d !== 32'h44) begin n_err++; $display("FAIL conflict_refetch: got lat=%0d d=%h expected lat=5 d=00000044", lat, d); end
        n_cmp++; if (bus.missCount !== 32'd3 || m_misses !== 3) begin n_err++; $display("FAIL conflict_misscount: got %0d expected 3", bus.missCount); end
    endtask

    task automatic test_flush_idle();
        logic [31:0] d; int lat; int hits_before;
        @(negedge clk); #1;
        hits_before = m_hits;
        bus.iCacheFlush = 1'b1; bus.iCacheReq = 1'b1; bus.iCacheReadAddr = 32'h44;
        #1;
        n_cmp++; if (bus.iCacheReady !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b expected 0", bus.iCacheReady); end
        @(negedge clk);
        bus.iCacheFlush = 1'b0; bus.iCacheReq = 1'b0;
        model_flush();
        #1;
        n_cmp++; if (bus.iCacheValid !== 1'b0 || bus.hitCount !== 32'(hits_before)) begin n_err++; $display("FAIL flush_noaccept: got v=%b hits=%0d expected v=0 hits=%0d", bus.iCacheValid, bus.hitCount, hits_before); end
        void'(model_access(32'h44));
        fetch(32'h44, d, lat);
        n_cmp++; if (lat !== 5 || d !== 32'h44) begin n_err++; $display("FAIL flush_remiss: got lat=%0d d=%h expected lat=5 d=00000044", lat, d); end
        n_cmp++; if (bus.missCount !== 32'(m_misses)) begin n_err++; $display("FAIL flush_misscount: got %0d expected %0d", bus.missCount, m_misses); end
    endtask

    task automatic test_flush_refill();
        logic [31:0] d; int lat;
        @(negedge clk); #1;
        void'(model_access(32'h80));
        bus.iCacheReq = 1'b1; bus.iCacheReadAddr = 32'h80;
        @(negedge clk); #1;
        bus.iCacheReq = 1'b0;
        @(negedge clk); #1;
        bus.iCacheFlush = 1'b1;
        @(negedge clk); #1;
        bus.iCacheFlush = 1'b0;
        lat = 3;
        while (bus.iCacheValid !== 1'b1 && lat < 200) begin @(negedge clk); #1; lat++; end
        n_cmp++; if (lat !== 5 || bus.iCacheReadData !== 32'h80) begin n_err++; $display("FAIL flushref_fill: got lat=%0d d=%h expected lat=5 d=00000080", lat, bus.iCacheReadData); end
        model_flush();
        @(negedge clk); #1;
        n_cmp++; if (bus.iCacheReady !== 1'b0) begin n_err++; $display("FAIL flushref_pending_ready: got %b expected 0", bus.iCacheReady); end
        @(negedge clk); #1;
        n_cmp++; if (bus.iCacheReady !== 1'b1) begin n_err++; $display("FAIL flushref_ready_back: got %b expected 1", bus.iCacheReady); end
        void'(model_access(32'h80));
        fetch(32'h80, d, lat);
        n_cmp++; if (lat !== 5 || d !== 32'h80) begin n_err++; $display("FAIL flushref_remiss: got lat=%0d d=%h expected lat=5 d=00000080", lat, d); end
    endtask

    task automatic test_stall();
        logic [31:0] d; int lat;
        ack_mode = 1; unstable = 0;
        beat_log.delete();
        void'(model_access(32'h208));
        fetch(32'h208, d, lat);
        n_cmp++; if (lat !== 3 * WORDS + 1 || d !== 32'h208) begin n_err++; $display("FAIL stall_resp: got lat=%0d d=%h expected lat=%0d d=00000208", lat, d, 3 * WORDS + 1); end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL stall_addr_stable: got %0d changes expected 0", unstable); end
        n_cmp++; if (beat_log.size() !== 4 || beat_log[0] !== 32'h200 || beat_log[3] !== 32'h20C) begin n_err++; $display("FAIL stall_beats: got n=%0d expected 4 beats 200..20c", beat_log.size()); end
        ack_mode = 0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d; int lat;
        @(negedge clk); #1;
        bus.iCacheFlush = 1'b1;
        @(negedge clk); #1;
        bus.iCacheFlush = 1'b0;
        bus.iCacheReq = 1'b1; bus.iCacheReadAddr = 32'h44;
        @(negedge clk); #1;
        bus.iCacheReq = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.memReq !== 1'b0) begin n_err++; $display("FAIL rstmid_memreq: got %b expected 0", bus.memReq); end
        rst = 1'b0;
        model_flush(); m_hits = 0; m_misses = 0;
        n_cmp++; if (bus.missCount !== 32'h0 || bus.iCacheReady !== 1'b1) begin n_err++; $display("FAIL rstmid_state: got miss=%0d ready=%b expected 0/1", bus.missCount, bus.iCacheReady); end
        beat_log.delete();
        void'(model_access(32'h44));
        fetch(32'h44, d, lat);
        n_cmp++; if (lat !== 5 || d !== 32'h44 || beat_log.size() !== 4) begin n_err++; $display("FAIL rstmid_refill: got lat=%0d d=%h beats=%0d expected 5/00000044/4", lat, d, beat_log.size()); end
        n_cmp++; if (bus.missCount !== 32'd1) begin n_err++; $display("FAIL rstmid_misscount: got %0d expected 1", bus.missCount); end
    endtask

    task automatic test_random();
        logic [31:0] a, d; int lat; bit h;
        ack_mode = 2; unstable = 0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); #1;
                bus.iCacheFlush = 1'b1;
                @(negedge clk); #1;
                bus.iCacheFlush = 1'b0;
                model_flush();
            end
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            h = model_access(a);
            beat_log.delete();
            fetch(a, d, lat);
            n_cmp++; if (d !== (a & ~32'h3)) begin n_err++; $display("FAIL rand_data[%0d]: addr=%h got %h expected %h", n, a, d, a & ~32'h3); end
            if (h) begin
                n_cmp++; if (lat !== 1 || beat_log.size() !== 0) begin n_err++; $display("FAIL rand_hit[%0d]: addr=%h got lat=%0d beats=%0d expected 1/0", n, a, lat, beat_log.size()); end
            end else begin
                n_cmp++; if (lat < WORDS + 1 || beat_log.size() !== WORDS) begin n_err++; $display("FAIL rand_miss[%0d]: addr=%h got lat=%0d beats=%0d expected >=%0d/%0d", n, a, lat, beat_log.size(), WORDS + 1, WORDS); end
                for (int i = 0; i < beat_log.size(); i++) begin
                    n_cmp++; if (beat_log[i] !== ((a & ~32'hF) + 32'(4 * i))) begin n_err++; $display("FAIL rand_beat[%0d.%0d]: got %h expected %h", n, i, beat_log[i], (a & ~32'hF) + 32'(4 * i)); end
                end
            end
        end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL rand_addr_stable: got %0d changes expected 0", unstable); end
        n_cmp++; if (bus.hitCount !== 32'(m_hits) || bus.missCount !== 32'(m_misses)) begin n_err++; $display("FAIL rand_counts: got %0d/%0d expected %0d/%0d", bus.hitCount, bus.missCount, m_hits, m_misses); end
        ack_mode = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.iCacheReq = 1'b0; bus.iCacheReadAddr = '0; bus.iCacheFlush = 1'b0;
        bus.memAck = 1'b0; bus.memRdata = '0;
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_flush_idle();
        test_flush_refill();
        test_stall();
        test_reset_mid_refill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
